// File: rtl/err_monitor.sv
// Run-time error monitor: watches retire/illegal/misalign/halt activity, latches
// the first error cause and the cycle it was seen, and counts elapsed cycles.
module err_monitor #(
  parameter int unsigned WDOG_LIMIT = 16,
  parameter int unsigned CYC_LIMIT  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        illegal,
  input  logic        misalign,
  input  logic        halt,
  input  logic        clr,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [31:0] err_cycle,
  output logic [31:0] cyc_cnt,
  output logic [1:0]  state
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned CODE_W = 3;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYC_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [CODE_W-1:0] CODE_NONE     = 3'd0;
  localparam logic [CODE_W-1:0] CODE_ILLEGAL  = 3'd1;
  localparam logic [CODE_W-1:0] CODE_MISALIGN = 3'd2;
  localparam logic [CODE_W-1:0] CODE_WDOG     = 3'd3;
  localparam logic [CODE_W-1:0] CODE_CYCLIM   = 3'd4;
  localparam logic [CODE_W-1:0] CODE_POSTHALT = 3'd5;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HALTED = 2'b01,
    ERROR  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [CODE_W-1:0] err_code_q, err_code_d;
  logic [CNT_W-1:0]  err_cycle_q, err_cycle_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CODE_W-1:0] cause;
  logic              in_err;

  // Bit 1 set covers both ERROR and the unreachable 2'b11 encoding.
  assign in_err = state_q[1];

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_cycle_d = err_cycle_q;
    cyc_cnt_d   = cyc_cnt_q;
    idle_d      = idle_q;
    cause       = CODE_NONE;

    if (!in_err && (cyc_cnt_q != CNT_MAX)) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (illegal) begin
          cause = CODE_ILLEGAL;
        end else if (misalign) begin
          cause = CODE_MISALIGN;
        end else if (!retire && (idle_q == WDOG_LAST)) begin
          cause = CODE_WDOG;
        end else if (cyc_cnt_q == CYC_LAST) begin
          cause = CODE_CYCLIM;
        end
        idle_d = retire ? '0 : idle_q + CNT_W'(1);
        if (cause != CODE_NONE) begin
          state_d = ERROR;
        end else if (halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (retire || illegal || misalign) begin
          cause   = CODE_POSTHALT;
          state_d = ERROR;
        end
      end
      default: begin
        if (clr) begin
          state_d     = RUN;
          err_d       = 1'b0;
          err_code_d  = CODE_NONE;
          err_cycle_d = '0;
          idle_d      = '0;
        end
      end
    endcase

    if (cause != CODE_NONE) begin
      err_d       = 1'b1;
      err_code_d  = cause;
      err_cycle_d = cyc_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      err_q       <= 1'b0;
      err_code_q  <= CODE_NONE;
      err_cycle_q <= '0;
      cyc_cnt_q   <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_cycle_q <= err_cycle_d;
      cyc_cnt_q   <= cyc_cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_cycle = err_cycle_q;
  assign cyc_cnt   = cyc_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_err_monitor.sv
// Self-checking bench for err_monitor: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the monitor's rules.
module tb_err_monitor;

  localparam int unsigned WDOG = 16;
  localparam int unsigned CYCL = 100;

  logic        clk = 1'b0;
  logic        rst, retire, illegal, misalign, halt, clr;
  logic        err;
  logic [2:0]  err_code;
  logic [31:0] err_cycle, cyc_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: 0 = running, 1 = halted, 2 = error latched
  int          m_mode;
  logic [31:0] m_cyc, m_idle, m_ecyc;
  int          m_code;
  bit          m_err;

  always #5 clk = ~clk;

  err_monitor #(.WDOG_LIMIT(WDOG), .CYC_LIMIT(CYCL)) dut (
    .clk(clk), .rst(rst), .retire(retire), .illegal(illegal),
    .misalign(misalign), .halt(halt), .clr(clr), .err(err),
    .err_code(err_code), .err_cycle(err_cycle), .cyc_cnt(cyc_cnt), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One rising edge of the monitor's rules applied to the current inputs.
  task automatic model_edge();
    int cause;
    int nxt;
    if (!rst) begin
      m_mode = 0; m_cyc = 0; m_idle = 0; m_err = 0; m_code = 0; m_ecyc = 0;
      return;
    end
    cause = 0;
    nxt   = m_mode;
    if (m_mode == 0) begin
      if (illegal)                               cause = 1;
      else if (misalign)                         cause = 2;
      else if (!retire && m_idle == 32'(WDOG-1)) cause = 3;
      else if (m_cyc == 32'(CYCL-1))             cause = 4;
      m_idle = retire ? 32'd0 : m_idle + 32'd1;
      if (cause != 0) nxt = 2;
      else if (halt)  nxt = 1;
    end else if (m_mode == 1) begin
      if (retire || illegal || misalign) begin
        cause = 5;
        nxt   = 2;
      end
    end else if (clr) begin
      nxt = 0; m_err = 0; m_code = 0; m_ecyc = 0; m_idle = 0;
    end
    if (cause != 0) begin
      m_err = 1; m_code = cause; m_ecyc = m_cyc;
    end
    if (m_mode != 2 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
    m_mode = nxt;
  endtask

  task automatic compare_all();
    check("state",     32'(state),     32'(m_mode));
    check("err",       32'(err),       32'(m_err));
    check("err_code",  32'(err_code),  32'(m_code));
    check("err_cycle", err_cycle,      m_ecyc);
    check("cyc_cnt",   cyc_cnt,        m_cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    retire = 0; illegal = 0; misalign = 0; halt = 0; clr = 0;
  endtask

  // Leaves the bench in cycle 0 (first cycle with rst high).
  task automatic do_reset();
    quiet();
    rst = 0;
    step();
    rst = 1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    quiet();
    rst = 0;
    m_mode = 0; m_cyc = 0; m_idle = 0; m_err = 0; m_code = 0; m_ecyc = 0;
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cyc", cyc_cnt, 32'd0);
    rst = 1;

    // Halt at cycle 20 with steady retire
    do_reset();
    retire = 1;
    run_n(20);
    halt = 1;
    step();
    halt = 0; retire = 0;
    check("halt_state", 32'(state), 32'd1);
    check("halt_err", 32'(err), 32'd0);
    check("halt_cyc", cyc_cnt, 32'd21);
    run_n(5);
    check("halt_cyc_runs", cyc_cnt, 32'd26);

    // Watchdog with no retire
    do_reset();
    run_n(15);
    check("wdog_pre", 32'(err), 32'd0);
    step();
    check("wdog_err", 32'(err), 32'd1);
    check("wdog_code", 32'(err_code), 32'd3);
    check("wdog_ecyc", err_cycle, 32'd15);

    // Illegal beats misalign; later misalign does not overwrite
    do_reset();
    retire = 1;
    run_n(7);
    illegal = 1; misalign = 1;
    step();
    illegal = 0; misalign = 0;
    check("prio_code", 32'(err_code), 32'd1);
    check("prio_ecyc", err_cycle, 32'd7);
    run_n(3);
    misalign = 1;
    step();
    misalign = 0;
    check("sticky_code", 32'(err_code), 32'd1);
    check("sticky_ecyc", err_cycle, 32'd7);

    // Cycle limit
    do_reset();
    retire = 1;
    run_n(100);
    check("cyclim_code", 32'(err_code), 32'd4);
    check("cyclim_ecyc", err_cycle, 32'd99);
    run_n(10);
    check("cyclim_hold", cyc_cnt, 32'd100);

    // Post-halt activity then clear
    do_reset();
    retire = 1;
    run_n(10);
    retire = 0; halt = 1;
    step();
    halt = 0;
    run_n(3);
    retire = 1;
    step();
    retire = 0;
    check("posthalt_err", 32'(err), 32'd1);
    check("posthalt_code", 32'(err_code), 32'd5);
    run_n(5);
    clr = 1; illegal = 1;
    step();
    clr = 0; illegal = 0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    check("clr_ecyc", err_cycle, 32'd0);
    retire = 1;
    run_n(3);
    retire = 0;

    // Reset out of ERROR
    illegal = 1;
    step();
    illegal = 0;
    rst = 0;
    step();
    rst = 1;
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_cyc2", cyc_cnt, 32'd0);

    // Randomized traffic with varying retire density
    for (int seg = 0; seg < 8; seg++) begin
      int rp;
      rp = (seg % 4 == 0) ? 95 : (seg % 4 == 1) ? 50 : (seg % 4 == 2) ? 3 : 80;
      do_reset();
      for (int i = 0; i < 400; i++) begin
        retire   = ($urandom_range(99) < rp);
        illegal  = ($urandom_range(99) < 2);
        misalign = ($urandom_range(99) < 2);
        halt     = ($urandom_range(99) < 3);
        clr      = ($urandom_range(99) < 12);
        rst      = ($urandom_range(199) != 0);
        step();
      end
      rst = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
